eth_header_rx: RTL and testbench
================================

Name: eth_header_rx

Overview:
- Receive-side Ethernet II header parser.
- Sits after the preamble/SFD detector, in the same aclk domain as the rest of the MAC datapath.
- Captures destination MAC, source MAC and EtherType from the incoming byte stream, filters on the destination address, and classifies the frame as ARP (0x0806) or IPv4 (0x0800).
- Signals completion with one-cycle done pulses to the ARP/IP payload parsers downstream.

Parameters:
- ADDR_FILTER, 1, 1 = accept only dest == local_mac or FF:FF:FF:FF:FF:FF; 0 = accept any dest.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset, asynchronous, active-low.
- local_mac  input  48  own MAC address; sampled when the last dest byte is accepted.
- preamble_sfd_rx_done  input  1  one-cycle pulse; the next valid byte is dest MAC byte 0.
- data_in  input  8  received byte, MSB-first field order (byte 0 = bits 47:40).
- data_in_valid  input  1  qualifies data_in; bytes are consumed only when high.
- rx_abort  input  1  frame error / carrier loss; discards the header in progress.
- mac_d_addr  output  48  captured destination MAC.
- mac_s_addr  output  48  captured source MAC.
- eth_type  output  16  captured EtherType.
- eth_header_arp_rx_done  output  1  one-cycle pulse: header accepted, type ARP.
- eth_header_ip_rx_done  output  1  one-cycle pulse: header accepted, type IPv4.
- eth_header_drop  output  1  one-cycle pulse: header rejected (address mismatch or unsupported type).
- vlan_tci  output  16  present only with ETH_HEADER_RX_VLAN_EN.

Behaviour:
- Reset (async, aresetn=0): state=WAIT_START, 3-bit byte counter=0, all outputs 0.
- States: WAIT_START, MAC_DESTINATION_RX, MAC_SOURCE_RX, ETH_TYPE_RX (plus VLAN_TAG_RX with the optional feature).
- WAIT_START:
  - preamble_sfd_rx_done=1 -> MAC_DESTINATION_RX, counter=0.
  - A byte valid in the same cycle as the pulse is ignored.
- Field capture:
  - Each state accepts one byte per data_in_valid cycle and shifts it into the field register, MSB first.
  - data_in_valid=0 holds state and counter; gaps of any length are allowed.
- MAC_DESTINATION_RX: after 6 bytes (counter 0..5) -> MAC_SOURCE_RX, counter=0.
  - The address-match result is registered at this point: dest == local_mac, or dest all-ones.
- MAC_SOURCE_RX: after 6 bytes -> ETH_TYPE_RX, counter=0.
- ETH_TYPE_RX: after 2 bytes -> WAIT_START.
  - On the cycle after the 2nd type byte is accepted, exactly one of three pulses asserts for 1 cycle:
    - ip_rx_done: match (or ADDR_FILTER=0) and type 0x0800.
    - arp_rx_done: match (or ADDR_FILTER=0) and type 0x0806.
    - eth_header_drop: all other cases.
- Latency: done/drop pulse 1 cycle after the last header byte.
- Field outputs mac_d_addr, mac_s_addr, eth_type:
  - Update live during capture.
  - Stable from the done pulse until the next preamble_sfd_rx_done.
- Done pulses are mutually exclusive and never asserted outside the cycle after the last type byte.
- Boundary conditions:
  - rx_abort=1 in any state: return to WAIT_START, counter=0, no done/drop pulse. rx_abort has priority over the same-cycle byte.
  - preamble_sfd_rx_done=1 while not in WAIT_START: restart at MAC_DESTINATION_RX, counter=0, no pulse for the partial header. rx_abort wins if both are asserted.
  - aresetn deasserted mid-header: immediate return to reset values; no pulse.

Optional Feature:
- Macro: ETH_HEADER_RX_VLAN_EN.
- Defined:
  - A type value of 0x8100 moves to VLAN_TAG_RX.
  - VLAN_TAG_RX captures 2 TCI bytes into vlan_tci, then returns to ETH_TYPE_RX for the inner EtherType.
  - Classification uses the inner type; the done pulse comes 1 cycle after the last inner type byte.
  - Only one tag is accepted; a second 0x8100 -> drop.
  - vlan_tci resets to 0 and is cleared to 0 at each preamble_sfd_rx_done.
- Undefined:
  - No vlan_tci port and no VLAN_TAG_RX state.
  - 0x8100 is an unsupported type -> eth_header_drop.

Test Plan:
- local_mac=02:00:00:00:00:01, SFD pulse, then continuous bytes: dest 02:00:00:00:00:01, src 00:11:22:33:44:55, type 08 00 -> ip_rx_done pulse 1 cycle after last byte; mac_s_addr=0x001122334455, eth_type=0x0800.
- Dest FF:FF:FF:FF:FF:FF, type 08 06, data_in_valid toggled 1/0 every cycle -> arp_rx_done once; fields correct despite gaps.
- Dest 02:00:00:00:00:02, type 0x0800:
  - ADDR_FILTER=1 -> eth_header_drop only.
  - ADDR_FILTER=0 -> ip_rx_done.
- rx_abort after 4 source bytes, then a fresh SFD plus a valid ARP header -> no pulse for the first frame, arp_rx_done for the second; a second SFD pulse mid-dest gives the same result.
- Type 0x86DD -> eth_header_drop. With VLAN_EN: 81 00 | 00 64 | 08 00 -> vlan_tci=0x0064, ip_rx_done. Without VLAN_EN: 0x8100 -> drop.
- aresetn low in ETH_TYPE_RX -> all outputs 0 immediately; no pulses after release until a new SFD.

Source files
------------

// File: rtl/eth_header_rx.sv
// Ethernet II receive header parser: captures dest/src MAC and EtherType, filters and classifies ARP/IPv4.
// Define ETH_HEADER_RX_VLAN_EN to accept a single 802.1Q tag and expose vlan_tci.
module eth_header_rx #(
  parameter int unsigned ADDR_FILTER = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [47:0] local_mac,
  input  logic        preamble_sfd_rx_done,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  input  logic        rx_abort,
  output logic [47:0] mac_d_addr,
  output logic [47:0] mac_s_addr,
  output logic [15:0] eth_type,
  output logic        eth_header_arp_rx_done,
  output logic        eth_header_ip_rx_done,
`ifdef ETH_HEADER_RX_VLAN_EN
  output logic [15:0] vlan_tci,
`endif
  output logic        eth_header_drop
);

`ifdef ETH_HEADER_RX_VLAN_EN
  typedef enum logic [2:0] {
    WAIT_START, MAC_DESTINATION_RX, MAC_SOURCE_RX, ETH_TYPE_RX, VLAN_TAG_RX
  } state_t;
`else
  typedef enum logic [2:0] {
    WAIT_START, MAC_DESTINATION_RX, MAC_SOURCE_RX, ETH_TYPE_RX
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [47:0] dest_q, dest_d, src_q, src_d;
  logic [15:0] type_q, type_d;
  logic        match_q, match_d;
  logic        arp_q, arp_d, ip_q, ip_d, drop_q, drop_d;
  logic        take, restart;
  logic [15:0] type_full;
  logic [47:0] dest_full;
  logic        accept;
`ifdef ETH_HEADER_RX_VLAN_EN
  logic [15:0] tci_q, tci_d;
  logic        vlan_seen_q, vlan_seen_d;
  logic        is_tag;
`endif

  // Abort beats SFD, and both beat a byte presented in the same cycle.
  assign restart   = preamble_sfd_rx_done && !rx_abort;
  assign take      = data_in_valid && !rx_abort && !preamble_sfd_rx_done && (state_q != WAIT_START);
  assign type_full = {type_q[7:0], data_in};
  assign dest_full = {dest_q[39:0], data_in};
  assign accept    = (ADDR_FILTER == 0) || match_q;
`ifdef ETH_HEADER_RX_VLAN_EN
  assign is_tag    = (type_full == 16'h8100) && !vlan_seen_q;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= WAIT_START;
      cnt_q       <= '0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      match_q     <= 1'b0;
      arp_q       <= 1'b0;
      ip_q        <= 1'b0;
      drop_q      <= 1'b0;
`ifdef ETH_HEADER_RX_VLAN_EN
      tci_q       <= '0;
      vlan_seen_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      match_q     <= match_d;
      arp_q       <= arp_d;
      ip_q        <= ip_d;
      drop_q      <= drop_d;
`ifdef ETH_HEADER_RX_VLAN_EN
      tci_q       <= tci_d;
      vlan_seen_q <= vlan_seen_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rx_abort) begin
      state_d = WAIT_START;
      cnt_d   = '0;
    end else if (restart) begin
      state_d = MAC_DESTINATION_RX;
      cnt_d   = '0;
    end else if (take) begin
      cnt_d = cnt_q + 3'd1;
      case (state_q)
        MAC_DESTINATION_RX: if (cnt_q == 3'd5) begin state_d = MAC_SOURCE_RX; cnt_d = '0; end
        MAC_SOURCE_RX:      if (cnt_q == 3'd5) begin state_d = ETH_TYPE_RX;   cnt_d = '0; end
        ETH_TYPE_RX: if (cnt_q == 3'd1) begin
          cnt_d   = '0;
`ifdef ETH_HEADER_RX_VLAN_EN
          state_d = is_tag ? VLAN_TAG_RX : WAIT_START;
`else
          state_d = WAIT_START;
`endif
        end
`ifdef ETH_HEADER_RX_VLAN_EN
        VLAN_TAG_RX: if (cnt_q == 3'd1) begin state_d = ETH_TYPE_RX; cnt_d = '0; end
`endif
        default: begin state_d = WAIT_START; cnt_d = '0; end
      endcase
    end
  end

  always_comb begin
    dest_d  = dest_q;
    src_d   = src_q;
    type_d  = type_q;
    match_d = match_q;
    arp_d   = 1'b0;
    ip_d    = 1'b0;
    drop_d  = 1'b0;
`ifdef ETH_HEADER_RX_VLAN_EN
    tci_d       = tci_q;
    vlan_seen_d = vlan_seen_q;
    if (restart) begin
      tci_d       = '0;
      vlan_seen_d = 1'b0;
    end
`endif
    if (take) begin
      case (state_q)
        MAC_DESTINATION_RX: begin
          dest_d = dest_full;
          if (cnt_q == 3'd5) match_d = (dest_full == local_mac) || (dest_full == '1);
        end
        MAC_SOURCE_RX: src_d = {src_q[39:0], data_in};
        ETH_TYPE_RX: begin
          type_d = type_full;
          if (cnt_q == 3'd1) begin
`ifdef ETH_HEADER_RX_VLAN_EN
            if (is_tag) begin
              vlan_seen_d = 1'b1;
            end else begin
`else
            begin
`endif
              ip_d   = accept && (type_full == 16'h0800);
              arp_d  = accept && (type_full == 16'h0806);
              drop_d = !(accept && ((type_full == 16'h0800) || (type_full == 16'h0806)));
            end
          end
        end
`ifdef ETH_HEADER_RX_VLAN_EN
        VLAN_TAG_RX: tci_d = {tci_q[7:0], data_in};
`endif
        default: ;
      endcase
    end
  end

  assign mac_d_addr             = dest_q;
  assign mac_s_addr             = src_q;
  assign eth_type               = type_q;
  assign eth_header_arp_rx_done = arp_q;
  assign eth_header_ip_rx_done  = ip_q;
  assign eth_header_drop        = drop_q;
`ifdef ETH_HEADER_RX_VLAN_EN
  assign vlan_tci               = tci_q;
`endif

endmodule

// File: tb/tb_eth_header_rx.sv
// Scoreboard bench for eth_header_rx: two instances (address filter on/off) share one stimulus stream.
module tb_eth_header_rx;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [47:0] local_mac;
  logic        sfd, valid, abort;
  logic [7:0]  data;
  logic [47:0] d1, s1, d0, s0;
  logic [15:0] t1, t0, tci1, tci0;
  logic        arp1, ip1, drop1, arp0, ip0, drop0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  localparam int ARP = 0, IP = 1, DROP = 2;
  localparam logic [47:0] LMAC = 48'h020000000001;
  localparam logic [47:0] SRC  = 48'h001122334455;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;
    logic [47:0] d, s;
    logic [15:0] t, tci;
    int          cyc;
  } exp_t;
  exp_t q1[$], q0[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  eth_header_rx #(.ADDR_FILTER(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .local_mac(local_mac), .preamble_sfd_rx_done(sfd),
    .data_in(data), .data_in_valid(valid), .rx_abort(abort),
    .mac_d_addr(d1), .mac_s_addr(s1), .eth_type(t1),
    .eth_header_arp_rx_done(arp1), .eth_header_ip_rx_done(ip1),
`ifdef ETH_HEADER_RX_VLAN_EN
    .vlan_tci(tci1),
`endif
    .eth_header_drop(drop1));

  eth_header_rx #(.ADDR_FILTER(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .local_mac(local_mac), .preamble_sfd_rx_done(sfd),
    .data_in(data), .data_in_valid(valid), .rx_abort(abort),
    .mac_d_addr(d0), .mac_s_addr(s0), .eth_type(t0),
    .eth_header_arp_rx_done(arp0), .eth_header_ip_rx_done(ip0),
`ifdef ETH_HEADER_RX_VLAN_EN
    .vlan_tci(tci0),
`endif
    .eth_header_drop(drop0));

`ifndef ETH_HEADER_RX_VLAN_EN
  assign tci1 = '0;
  assign tci0 = '0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic arp, input logic ip, input logic drop,
                     input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                     input logic [15:0] tci);
    exp_t e;
    int   k;
    if (!(arp || ip || drop)) return;
    chk($sformatf("dut%0d_onehot", id), 64'($countones({arp, ip, drop})), 64'd1);
    k = arp ? ARP : (ip ? IP : DROP);
    if ((id == 1 && q1.size() == 0) || (id == 0 && q0.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_pulse actual=kind%0d required=none", id, k);
      return;
    end
    e = (id == 1) ? q1.pop_front() : q0.pop_front();
    chk($sformatf("dut%0d_kind", id), 64'(k), 64'(e.kind));
    chk($sformatf("dut%0d_latency_cycle", id), 64'(cyc), 64'(e.cyc));
    chk($sformatf("dut%0d_mac_d_addr", id), 64'(d), 64'(e.d));
    chk($sformatf("dut%0d_mac_s_addr", id), 64'(s), 64'(e.s));
    chk($sformatf("dut%0d_eth_type", id), 64'(t), 64'(e.t));
    chk($sformatf("dut%0d_vlan_tci", id), 64'(tci), 64'(e.tci));
  endtask

  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      mon(1, arp1, ip1, drop1, d1, s1, t1, tci1);
      mon(0, arp0, ip0, drop0, d0, s0, t0, tci0);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_sfd();
    sfd = 1'b1;
    valid = 1'b0;
    tick();
    sfd = 1'b0;
  endtask

  task automatic send_bytes(input bq_t b, input bit gapped);
    foreach (b[i]) begin
      data = b[i];
      valid = 1'b1;
      tick();
      valid = 1'b0;
      if (gapped && i != b.size() - 1) tick();
    end
  endtask

  function automatic bq_t hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    bq_t b;
    for (int i = 5; i >= 0; i--) b.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(s[i*8 +: 8]);
    b.push_back(t[15:8]);
    b.push_back(t[7:0]);
    return b;
  endfunction

  // Called right after the last header byte was captured; the pulse is due at the following negedge.
  task automatic expect_pulse(input int k1, input int k0, input logic [47:0] d, input logic [47:0] s,
                              input logic [15:0] t, input logic [15:0] tci);
    exp_t e;
    e.kind = k1; e.d = d; e.s = s; e.t = t; e.tci = tci; e.cyc = cyc;
    q1.push_back(e);
    e.kind = k0;
    q0.push_back(e);
  endtask

  task automatic frame(input bit do_sfd, input logic [47:0] d, input logic [47:0] s,
                       input logic [15:0] t, input bit gapped, input int k1, input int k0);
    if (do_sfd) send_sfd();
    send_bytes(hdr(d, s, t), gapped);
    expect_pulse(k1, k0, d, s, t, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    aresetn = 1'b0; local_mac = LMAC; sfd = 1'b0; valid = 1'b0; abort = 1'b0; data = '0;
    tick(); tick();
    chk("reset_mac_d_addr", 64'(d1), 64'd0);
    chk("reset_mac_s_addr", 64'(s1), 64'd0);
    chk("reset_eth_type", 64'(t1), 64'd0);
    chk("reset_pulses", 64'({arp1, ip1, drop1, arp0, ip0, drop0}), 64'd0);
    aresetn = 1'b1;
    tick();

    // IPv4 to own address, continuous bytes
    frame(1'b1, LMAC, SRC, 16'h0800, 1'b0, IP, IP);
    tick();
    // ARP broadcast with a gap after every byte
    frame(1'b1, 48'hFFFFFFFFFFFF, 48'hA0B1C2D3E4F5, 16'h0806, 1'b1, ARP, ARP);
    tick();
    // foreign destination: filtered instance drops, unfiltered accepts
    frame(1'b1, 48'h020000000002, SRC, 16'h0800, 1'b0, DROP, IP);
    tick();
    // unsupported type
    frame(1'b1, LMAC, SRC, 16'h86DD, 1'b0, DROP, DROP);
    tick();

    // abort after 4 source bytes with a byte in the same cycle, then a clean ARP frame
    send_sfd();
    b = hdr(LMAC, SRC, 16'h0806);
    b = b[0:9];
    send_bytes(b, 1'b0);
    abort = 1'b1; valid = 1'b1; data = 8'h66;
    tick();
    abort = 1'b0; valid = 1'b0;
    frame(1'b1, LMAC, 48'h112233445566, 16'h0806, 1'b0, ARP, ARP);
    tick();

    // second SFD mid-destination (same-cycle byte ignored) restarts the header
    send_sfd();
    b = hdr(LMAC, SRC, 16'h0800);
    b = b[0:2];
    send_bytes(b, 1'b0);
    sfd = 1'b1; valid = 1'b1; data = 8'hAA;
    tick();
    sfd = 1'b0; valid = 1'b0;
    frame(1'b0, 48'hFFFFFFFFFFFF, 48'h665544332211, 16'h0806, 1'b0, ARP, ARP);
    tick();

    // single 802.1Q tag
    send_sfd();
    send_bytes(hdr(LMAC, SRC, 16'h8100), 1'b0);
`ifdef ETH_HEADER_RX_VLAN_EN
    b = '{8'h00, 8'h64, 8'h08, 8'h00};
    send_bytes(b, 1'b0);
    expect_pulse(IP, IP, LMAC, SRC, 16'h0800, 16'h0064);
    tick();
    // a second tag is not accepted
    send_sfd();
    send_bytes(hdr(LMAC, SRC, 16'h8100), 1'b0);
    b = '{8'h00, 8'h64, 8'h81, 8'h00};
    send_bytes(b, 1'b0);
    expect_pulse(DROP, DROP, LMAC, SRC, 16'h8100, 16'h0064);
`else
    expect_pulse(DROP, DROP, LMAC, SRC, 16'h8100, 16'h0000);
    b = '{8'h00, 8'h64, 8'h08, 8'h00};
    send_bytes(b, 1'b0);
`endif
    tick();

    // asynchronous reset while in ETH_TYPE_RX
    send_sfd();
    b = hdr(LMAC, SRC, 16'h0800);
    b = b[0:12];
    send_bytes(b, 1'b0);
    #2 aresetn = 1'b0;
    #1;
    chk("midreset_mac_d_addr", 64'(d1), 64'd0);
    chk("midreset_mac_s_addr", 64'(s1), 64'd0);
    chk("midreset_eth_type", 64'(t1), 64'd0);
    chk("midreset_vlan_tci", 64'(tci1), 64'd0);
    chk("midreset_pulses", 64'({arp1, ip1, drop1, arp0, ip0, drop0}), 64'd0);
    tick(); tick();
    aresetn = 1'b1;
    // bytes without a new SFD must produce no pulse
    send_bytes(hdr(LMAC, SRC, 16'h0800), 1'b0);
    tick(); tick();
    frame(1'b1, LMAC, SRC, 16'h0806, 1'b0, ARP, ARP);
    repeat (5) tick();

    chk("dut1_pending_expectations", 64'(q1.size()), 64'd0);
    chk("dut0_pending_expectations", 64'(q0.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
